// File: rtl/snax_simbacore_launch_ctrl_if.sv
// Config/handshake bundle shared by the CSR manager, the launch controller and the SimbaCore datapath.
// Signal suffixes are named from the controller's point of view.
interface snax_simbacore_launch_ctrl_if #(
  parameter int unsigned NumRwCsr = 6,
  parameter int unsigned NumRoCsr = 2
);
  logic [NumRwCsr-1:0][31:0] csr_reg_rw_set_i;
  logic                      csr_reg_set_valid_i;
  logic                      csr_reg_set_ready_o;
  logic [NumRoCsr-1:0][31:0] csr_reg_ro_set_o;
  logic [NumRwCsr-1:0][31:0] acc_cfg_o;
  logic                      acc_start_valid_o;
  logic                      acc_start_ready_i;
  logic                      acc_done_i;

  modport master (
    output csr_reg_rw_set_i, csr_reg_set_valid_i, acc_start_ready_i, acc_done_i,
    input  csr_reg_set_ready_o, csr_reg_ro_set_o, acc_cfg_o, acc_start_valid_o
  );
  modport slave (
    input  csr_reg_rw_set_i, csr_reg_set_valid_i, acc_start_ready_i, acc_done_i,
    output csr_reg_set_ready_o, csr_reg_ro_set_o, acc_cfg_o, acc_start_valid_o
  );
endinterface

// File: rtl/snax_simbacore_launch_ctrl.sv
// Double-buffered job launcher: one pending CSR slot, one active config register,
// start handshake towards the datapath plus job-cycle and job-count status words.
module snax_simbacore_launch_ctrl #(
  parameter int unsigned NumRwCsr = 6,
  parameter int unsigned NumRoCsr = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  snax_simbacore_launch_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {Idle, Launch, Busy} state_e;
  typedef logic [NumRwCsr-1:0][31:0] cfg_t;

  state_e      state_q, state_d;
  logic        p_full_q, p_full_d;
  cfg_t        p_q, p_d, a_q, a_d;
  logic [31:0] job_cycles_q, job_cycles_d;
  logic [15:0] jobs_done_q, jobs_done_d;
  logic        accept;
  logic [31:0] cyc_inc;

  // Ready depends only on the pending flag, so there is no input-to-ready path.
  assign accept  = bus.csr_reg_set_valid_i & ~p_full_q;
  assign cyc_inc = (job_cycles_q == '1) ? job_cycles_q : job_cycles_q + 32'd1;

  always_comb begin
    state_d      = state_q;
    p_full_d     = p_full_q;
    p_d          = p_q;
    a_d          = a_q;
    job_cycles_d = job_cycles_q;
    jobs_done_d  = jobs_done_q;
    // Accept only happens with P empty and the transfer only with P full, so they never collide.
    if (accept) begin
      p_d      = bus.csr_reg_rw_set_i;
      p_full_d = 1'b1;
    end
    unique case (state_q)
      Idle: if (p_full_q) begin
        a_d          = p_q;
        p_full_d     = 1'b0;
        job_cycles_d = '0;
        state_d      = Launch;
      end
      Launch: begin
        job_cycles_d = cyc_inc;
        if (bus.acc_start_ready_i) state_d = Busy;
      end
      Busy: begin
        job_cycles_d = cyc_inc;
        if (bus.acc_done_i) begin
          jobs_done_d = jobs_done_q + 16'd1;
          state_d     = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= Idle;
      p_full_q     <= 1'b0;
      p_q          <= '0;
      a_q          <= '0;
      job_cycles_q <= '0;
      jobs_done_q  <= '0;
    end else begin
      state_q      <= state_d;
      p_full_q     <= p_full_d;
      p_q          <= p_d;
      a_q          <= a_d;
      job_cycles_q <= job_cycles_d;
      jobs_done_q  <= jobs_done_d;
    end
  end

  assign bus.csr_reg_set_ready_o = ~p_full_q;
  assign bus.acc_start_valid_o   = (state_q == Launch);
  assign bus.acc_cfg_o           = a_q;
  assign bus.csr_reg_ro_set_o[0] = {jobs_done_q, 14'b0, p_full_q, state_q != Idle};
  assign bus.csr_reg_ro_set_o[1] = job_cycles_q;

  for (genvar g = 2; g < NumRoCsr; g++) begin : g_ro_tie
    assign bus.csr_reg_ro_set_o[g] = '0;
  end
endmodule

// File: tb/tb_snax_simbacore_launch_ctrl.sv
// Bench for the SimbaCore launch controller: directed vector table, hand-written corner
// sequences and random traffic checked against a transaction-level model.
module tb_snax_simbacore_launch_ctrl;
  localparam int NRW = 6;
  localparam int NRO = 2;
  typedef logic [NRW-1:0][31:0] cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snax_simbacore_launch_ctrl_if #(.NumRwCsr(NRW), .NumRoCsr(NRO)) bif ();
  snax_simbacore_launch_ctrl #(.NumRwCsr(NRW), .NumRoCsr(NRO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit mdl_on = 1'b1;

  // Reference model: pending configs in a queue, phase as two flags, counters as plain ints.
  cfg_t   m_pend[$];
  cfg_t   m_act;
  bit     m_launch, m_run;
  longint m_cyc;
  int     m_jobs;

  function automatic cfg_t cfg_of(int b);
    cfg_t c = '0;
    if (b != 0) for (int i = 0; i < NRW; i++) c[i] = 32'(b + i);
    return c;
  endfunction

  function automatic void mdl_reset();
    m_pend.delete();
    m_act = '0; m_launch = 0; m_run = 0; m_cyc = 0; m_jobs = 0;
  endfunction

  function automatic void mdl_edge();
    bit acc = bif.csr_reg_set_valid_i && (m_pend.size() == 0);
    if (!m_launch && !m_run) begin
      if (m_pend.size() != 0) begin
        m_act = m_pend.pop_front();
        m_launch = 1; m_cyc = 0;
      end
    end else begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (m_launch && bif.acc_start_ready_i) begin m_launch = 0; m_run = 1; end
      else if (m_run && bif.acc_done_i) begin m_run = 0; m_jobs = (m_jobs + 1) % 65536; end
    end
    if (acc) m_pend.push_back(bif.csr_reg_rw_set_i);
  endfunction

  task automatic chk(string nm, logic [NRW*32-1:0] act, logic [NRW*32-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cmp_model();
    logic [31:0] ro0;
    ro0 = {16'(m_jobs), 14'b0, m_pend.size() != 0, m_launch || m_run};
    chk("mdl_ready", bif.csr_reg_set_ready_o, m_pend.size() == 0);
    chk("mdl_start_valid", bif.acc_start_valid_o, m_launch);
    chk("mdl_cfg", bif.acc_cfg_o, m_act);
    chk("mdl_ro0", bif.csr_reg_ro_set_o[0], ro0);
    chk("mdl_ro1", bif.csr_reg_ro_set_o[1], 32'(m_cyc));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) mdl_reset(); else mdl_edge();
    #1;
    if (mdl_on) cmp_model();
  endtask

  typedef struct {
    bit          v;  int b;  bit r;  bit d;
    bit          e_rdy;  bit e_sv;  int e_cb;
    logic [31:0] e_ro0;  logic [31:0] e_ro1;
  } vec_t;
  vec_t tbl[17];

  initial begin
    // Job 1: immediate start, done 5 cycles after the start handshake (with a same-cycle done).
    // Job 2: start back-pressured 3 cycles, spurious dones in LAUNCH and IDLE.
    tbl = '{
      '{0, 0,    0, 1,  1, 0, 0,    32'h0,       32'd0},
      '{1, 1,    0, 0,  0, 0, 0,    32'h2,       32'd0},
      '{0, 0,    0, 0,  1, 1, 1,    32'h1,       32'd0},
      '{0, 0,    1, 1,  1, 0, 1,    32'h1,       32'd1},
      '{0, 0,    0, 0,  1, 0, 1,    32'h1,       32'd2},
      '{0, 0,    0, 0,  1, 0, 1,    32'h1,       32'd3},
      '{0, 0,    0, 0,  1, 0, 1,    32'h1,       32'd4},
      '{0, 0,    0, 0,  1, 0, 1,    32'h1,       32'd5},
      '{0, 0,    0, 1,  1, 0, 1,    32'h1_0000,  32'd6},
      '{1, 'h11, 0, 0,  0, 0, 1,    32'h1_0002,  32'd6},
      '{0, 0,    0, 0,  1, 1, 'h11, 32'h1_0001,  32'd0},
      '{0, 0,    0, 1,  1, 1, 'h11, 32'h1_0001,  32'd1},
      '{0, 0,    0, 0,  1, 1, 'h11, 32'h1_0001,  32'd2},
      '{0, 0,    0, 0,  1, 1, 'h11, 32'h1_0001,  32'd3},
      '{0, 0,    1, 0,  1, 0, 'h11, 32'h1_0001,  32'd4},
      '{0, 0,    0, 1,  1, 0, 'h11, 32'h2_0000,  32'd5},
      '{0, 0,    0, 1,  1, 0, 'h11, 32'h2_0000,  32'd5}
    };

    bif.csr_reg_rw_set_i    = '0;
    bif.csr_reg_set_valid_i = 1'b0;
    bif.acc_start_ready_i   = 1'b0;
    bif.acc_done_i          = 1'b0;
    mdl_reset();

    rst = 1'b1; step(); step(); rst = 1'b0;
    chk("rst_ready", bif.csr_reg_set_ready_o, 1'b1);
    chk("rst_start_valid", bif.acc_start_valid_o, 1'b0);
    chk("rst_cfg", bif.acc_cfg_o, '0);
    chk("rst_ro0", bif.csr_reg_ro_set_o[0], 32'h0);
    chk("rst_ro1", bif.csr_reg_ro_set_o[1], 32'h0);

    for (int k = 0; k < 17; k++) begin
      bif.csr_reg_set_valid_i = tbl[k].v;
      bif.csr_reg_rw_set_i    = cfg_of(tbl[k].b);
      bif.acc_start_ready_i   = tbl[k].r;
      bif.acc_done_i          = tbl[k].d;
      step();
      chk($sformatf("tbl%0d_ready", k), bif.csr_reg_set_ready_o, tbl[k].e_rdy);
      chk($sformatf("tbl%0d_sv", k), bif.acc_start_valid_o, tbl[k].e_sv);
      chk($sformatf("tbl%0d_cfg", k), bif.acc_cfg_o, cfg_of(tbl[k].e_cb));
      chk($sformatf("tbl%0d_ro0", k), bif.csr_reg_ro_set_o[0], tbl[k].e_ro0);
      chk($sformatf("tbl%0d_ro1", k), bif.csr_reg_ro_set_o[1], tbl[k].e_ro1);
    end
    bif.csr_reg_set_valid_i = 0; bif.acc_done_i = 0;

    // Double buffering: B waits in P while A runs, a third offer stalls.
    bif.acc_start_ready_i = 1;
    bif.csr_reg_rw_set_i = cfg_of('h21); bif.csr_reg_set_valid_i = 1; step();
    bif.csr_reg_set_valid_i = 0; step(); step();
    bif.csr_reg_rw_set_i = cfg_of('h31); bif.csr_reg_set_valid_i = 1; step();
    chk("db_ready_low", bif.csr_reg_set_ready_o, 1'b0);
    chk("db_pfull_bit", bif.csr_reg_ro_set_o[0][1], 1'b1);
    bif.csr_reg_rw_set_i = cfg_of('h41); step(); step();
    chk("db_third_stall", bif.csr_reg_set_ready_o, 1'b0);
    bif.csr_reg_set_valid_i = 0;
    bif.acc_done_i = 1; step(); bif.acc_done_i = 0;
    chk("db_cfg_still_a", bif.acc_cfg_o, cfg_of('h21));
    chk("db_idle_gap", bif.acc_start_valid_o, 1'b0);
    step();
    chk("db_b_start", bif.acc_start_valid_o, 1'b1);
    chk("db_cfg_b", bif.acc_cfg_o, cfg_of('h31));
    step(); bif.acc_done_i = 1; step(); bif.acc_done_i = 0; step();
    chk("db_c_dropped", bif.acc_start_valid_o, 1'b0);

    // Counter wrap / saturation with forced starting values.
    bif.csr_reg_rw_set_i = cfg_of('h51); bif.csr_reg_set_valid_i = 1; step();
    bif.csr_reg_set_valid_i = 0; step(); step();
    mdl_on = 0;
    force dut.jobs_done_q  = 16'hFFFF;
    force dut.job_cycles_q = 32'hFFFF_FFFE;
    step();
    release dut.jobs_done_q;
    release dut.job_cycles_q;
    step(); step();
    chk("sat_hold_busy", bif.csr_reg_ro_set_o[1], 32'hFFFF_FFFF);
    bif.acc_done_i = 1; step(); bif.acc_done_i = 0;
    chk("wrap_jobs", bif.csr_reg_ro_set_o[0][31:16], 16'h0000);
    chk("sat_cycles", bif.csr_reg_ro_set_o[1], 32'hFFFF_FFFF);

    // Reset mid-job with P full discards both jobs; a late done is ignored.
    rst = 1; step(); rst = 0; mdl_on = 1;
    bif.csr_reg_rw_set_i = cfg_of('h61); bif.csr_reg_set_valid_i = 1; step();
    bif.csr_reg_set_valid_i = 0; step(); step();
    bif.csr_reg_rw_set_i = cfg_of('h71); bif.csr_reg_set_valid_i = 1; step();
    bif.csr_reg_set_valid_i = 0;
    chk("rb_pfull", bif.csr_reg_set_ready_o, 1'b0);
    rst = 1; step(); rst = 0;
    chk("rb_ready", bif.csr_reg_set_ready_o, 1'b1);
    chk("rb_sv", bif.acc_start_valid_o, 1'b0);
    chk("rb_cfg", bif.acc_cfg_o, '0);
    chk("rb_ro0", bif.csr_reg_ro_set_o[0], 32'h0);
    chk("rb_ro1", bif.csr_reg_ro_set_o[1], 32'h0);
    bif.acc_done_i = 1; step(); bif.acc_done_i = 0; step();
    chk("rb_late_done_ro0", bif.csr_reg_ro_set_o[0], 32'h0);
    chk("rb_late_done_sv", bif.acc_start_valid_o, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cfg_t rc;
      for (int i = 0; i < NRW; i++) rc[i] = $urandom;
      bif.csr_reg_rw_set_i    = rc;
      bif.csr_reg_set_valid_i = $urandom_range(0, 1);
      bif.acc_start_ready_i   = ($urandom_range(0, 3) != 0);
      bif.acc_done_i          = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
